// File: rtl/ahb2apb_mem_bridge_if.sv
// ---------------------------------------------------------------------------
// ahb2apb_mem_bridge_if
// Bundles the signals that pass between an AHB-Lite master, the
// ahb2apb_mem_bridge and the APB word memory.
//   PCLKEN               APB clock enable (one CLK cycle wide pulses)
//   HSEL..HREADY         AHB-Lite slave-side inputs of the bridge
//   HREADYOUT/HRDATA/HRESP  AHB-Lite slave responses
//   PADDR..PENABLE       APB master outputs toward the memory
//   PRDATA               APB read data returned by the memory
// Modport slave is the bridge's view; modport master is the environment's
// view (AHB master plus APB memory).
// ---------------------------------------------------------------------------
interface ahb2apb_mem_bridge_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  PCLKEN;
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic [31:0]           HRDATA;
    logic                  HRESP;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;

    modport slave (
        input  PCLKEN, HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, PRDATA,
        output HREADYOUT, HRDATA, HRESP, PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport master (
        output PCLKEN, HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, PRDATA,
        input  HREADYOUT, HRDATA, HRESP, PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/ahb2apb_mem_bridge.sv
// ---------------------------------------------------------------------------
// ahb2apb_mem_bridge
// AHB-Lite slave to APB master bridge for a PREADY-less APB word memory.
// Every accepted AHB transfer becomes one APB setup+access pair that only
// advances on CLK edges with PCLKEN=1; the AHB data phase is stalled with
// HREADYOUT=0 until the APB access has completed.
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous active-high reset
//   bus    ahb2apb_mem_bridge_if.slave (AHB slave side + APB master side)
// ---------------------------------------------------------------------------
module ahb2apb_mem_bridge #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                       CLK,
    input  logic                       RESET,
    ahb2apb_mem_bridge_if.slave        bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PEND   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  hreadyout_q, hreadyout_d;
    logic [31:0]           hrdata_q, hrdata_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  accept_s;

    // Only valid transfer types with the bus ready start a new APB transfer.
    assign accept_s = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

    // Byte lanes, upper address bits and SEQ/NONSEQ distinction are unused.
    logic unused_s;
    assign unused_s = ^{bus.HSIZE, bus.HADDR[31:ADDR_WIDTH], bus.HTRANS[0]};

    // Next-state and next-output computation for the bridge FSM.
    always_comb begin
        state_d   = state_q;
        hrdata_d  = hrdata_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    paddr_d  = bus.HADDR[ADDR_WIDTH-1:0];
                    pwrite_d = bus.HWRITE;
                    state_d  = ST_PEND;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_PEND: begin
                // The AHB data phase is stalled here, so HWDATA is stable.
                pwdata_d = bus.HWDATA;
                if (bus.PCLKEN) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end else begin
                    state_d   = ST_PEND;
                end
            end
            ST_SETUP: begin
                if (bus.PCLKEN) begin
                    penable_d = 1'b1;
                    state_d   = ST_ACCESS;
                end else begin
                    state_d   = ST_SETUP;
                end
            end
            ST_ACCESS: begin
                // The memory commits a write on this same enabled edge.
                if (bus.PCLKEN) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (!pwrite_q) begin
                        hrdata_d = bus.PRDATA;
                    end else begin
                        hrdata_d = hrdata_q;
                    end
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_ACCESS;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        // HREADYOUT is registered, so it is derived from the next state.
        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    // State and output registers; reset drops PSEL/PENABLE immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hrdata_q    <= 32'h0000_0000;
            paddr_q     <= {ADDR_WIDTH{1'b0}};
            pwdata_q    <= 32'h0000_0000;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hrdata_q    <= hrdata_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.HRESP     = 1'b0;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;

endmodule
